// File: rtl/debug_frame_serializer_if.sv
// Frame-stream link between one debug serializer and the debug-interface arbiter.
// The serializer drives the frame side; the arbiter returns i_ready.
interface debug_frame_serializer_if #(
  parameter int NB_CONTROL_FRAME = 32
);
  logic [NB_CONTROL_FRAME-1:0] o_frame_to_interface;
  logic                        o_writing;
  logic                        o_last;
  logic                        o_busy;
  logic                        o_done;
  logic                        i_ready;

  modport master (
    output o_frame_to_interface, o_writing, o_last, o_busy, o_done,
    input  i_ready
  );

  modport slave (
    input  o_frame_to_interface, o_writing, o_last, o_busy, o_done,
    output i_ready
  );
endinterface

// File: rtl/debug_frame_serializer.sv
// Captures the MIPS debug vector when this controller ID is requested and streams
// it out LSB-frame first over a valid/ready link, zero-padding the final frame.
module debug_frame_serializer #(
  parameter int               NB_INPUT_SIZE    = 96,
  parameter int               NB_CONTROL_FRAME = 32,
  parameter int               NB_ID            = 6,
  parameter logic [NB_ID-1:0] CONTROLLER_ID    = NB_ID'(1)
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [NB_ID-1:0]         i_request_select,
  input  logic                     i_request_valid,
  input  logic [NB_INPUT_SIZE-1:0] i_data_from_mips,
  debug_frame_serializer_if.master bus
);

  localparam int N_FRAMES = (NB_INPUT_SIZE + NB_CONTROL_FRAME - 1) / NB_CONTROL_FRAME;
  localparam int NB_CNT   = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
  localparam int NB_TOTAL = N_FRAMES * NB_CONTROL_FRAME;
  localparam logic [NB_CNT-1:0] LAST_IDX = NB_CNT'(N_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_next_state;
  logic [NB_CNT-1:0]           r_counter;
  logic [NB_CONTROL_FRAME-1:0] r_snapshot [N_FRAMES];
  logic [NB_TOTAL-1:0]         w_padded;
  logic                        w_req_hit;
  logic                        w_is_last;
  logic                        w_xfer;

  assign w_req_hit = i_request_valid && (i_request_select == CONTROLLER_ID);
  assign w_is_last = (r_counter == LAST_IDX);
  assign w_xfer    = (r_state == ST_SEND) && bus.i_ready;

  // Zero-extend the live vector so the final frame carries zeros above the payload.
  always_comb begin
    w_padded = '0;
    w_padded[NB_INPUT_SIZE-1:0] = i_data_from_mips;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req_hit) w_next_state = ST_SEND;
        else           w_next_state = ST_IDLE;
      end
      ST_SEND: begin
        if (w_xfer && w_is_last) w_next_state = ST_DONE;
        else                     w_next_state = ST_SEND;
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Snapshot is only loaded from IDLE, so requests during SEND/DONE cannot disturb it.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_counter <= '0;
      for (int i = 0; i < N_FRAMES; i++) begin
        r_snapshot[i] <= '0;
      end
    end else if ((r_state == ST_IDLE) && w_req_hit) begin
      r_counter <= '0;
      for (int i = 0; i < N_FRAMES; i++) begin
        r_snapshot[i] <= w_padded[i*NB_CONTROL_FRAME +: NB_CONTROL_FRAME];
      end
    end else if (w_xfer && !w_is_last) begin
      r_counter <= r_counter + NB_CNT'(1);
    end else begin
      r_counter <= r_counter;
    end
  end

  always_comb begin
    bus.o_frame_to_interface = '0;
    bus.o_writing            = 1'b0;
    bus.o_last               = 1'b0;
    bus.o_busy               = 1'b0;
    bus.o_done               = 1'b0;
    case (r_state)
      ST_SEND: begin
        bus.o_frame_to_interface = r_snapshot[r_counter];
        bus.o_writing            = 1'b1;
        bus.o_last               = w_is_last;
        bus.o_busy               = 1'b1;
      end
      ST_DONE: begin
        bus.o_busy = 1'b1;
        bus.o_done = 1'b1;
      end
      default: begin
        bus.o_busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_debug_frame_serializer.sv
// Four serializers of different widths share one request bus; a queue-based
// reference model predicts every output of every instance on every cycle.
module tb_debug_frame_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  sel;
  logic        vld;
  logic [143:0] data_s  [4];
  logic        ready_s [4];
  logic [31:0] frame_s [4];
  logic        wr_s    [4];
  logic        last_s  [4];
  logic        busy_s  [4];
  logic        done_s  [4];

  int nbits [4] = '{96, 104, 144, 20};

  logic [31:0] exp_q [4][$];
  bit          done_pend [4];
  int          xfers [4];
  int          dones [4];
  int          n_checks = 0;
  int          n_fails  = 0;

  always #5 clk = ~clk;

  debug_frame_serializer_if #(.NB_CONTROL_FRAME(32)) if0 ();
  debug_frame_serializer_if #(.NB_CONTROL_FRAME(32)) if1 ();
  debug_frame_serializer_if #(.NB_CONTROL_FRAME(32)) if2 ();
  debug_frame_serializer_if #(.NB_CONTROL_FRAME(32)) if3 ();

  assign if0.i_ready = ready_s[0];
  assign if1.i_ready = ready_s[1];
  assign if2.i_ready = ready_s[2];
  assign if3.i_ready = ready_s[3];
  assign frame_s[0] = if0.o_frame_to_interface;
  assign frame_s[1] = if1.o_frame_to_interface;
  assign frame_s[2] = if2.o_frame_to_interface;
  assign frame_s[3] = if3.o_frame_to_interface;
  assign wr_s[0] = if0.o_writing;  assign wr_s[1] = if1.o_writing;
  assign wr_s[2] = if2.o_writing;  assign wr_s[3] = if3.o_writing;
  assign last_s[0] = if0.o_last;   assign last_s[1] = if1.o_last;
  assign last_s[2] = if2.o_last;   assign last_s[3] = if3.o_last;
  assign busy_s[0] = if0.o_busy;   assign busy_s[1] = if1.o_busy;
  assign busy_s[2] = if2.o_busy;   assign busy_s[3] = if3.o_busy;
  assign done_s[0] = if0.o_done;   assign done_s[1] = if1.o_done;
  assign done_s[2] = if2.o_done;   assign done_s[3] = if3.o_done;

  debug_frame_serializer #(.NB_INPUT_SIZE(96), .NB_CONTROL_FRAME(32), .NB_ID(6),
                           .CONTROLLER_ID(6'd1)) dut0 (
    .i_clock(clk), .i_reset(rst), .i_request_select(sel), .i_request_valid(vld),
    .i_data_from_mips(data_s[0][95:0]), .bus(if0.master));
  debug_frame_serializer #(.NB_INPUT_SIZE(104), .NB_CONTROL_FRAME(32), .NB_ID(6),
                           .CONTROLLER_ID(6'd2)) dut1 (
    .i_clock(clk), .i_reset(rst), .i_request_select(sel), .i_request_valid(vld),
    .i_data_from_mips(data_s[1][103:0]), .bus(if1.master));
  debug_frame_serializer #(.NB_INPUT_SIZE(144), .NB_CONTROL_FRAME(32), .NB_ID(6),
                           .CONTROLLER_ID(6'd3)) dut2 (
    .i_clock(clk), .i_reset(rst), .i_request_select(sel), .i_request_valid(vld),
    .i_data_from_mips(data_s[2][143:0]), .bus(if2.master));
  debug_frame_serializer #(.NB_INPUT_SIZE(20), .NB_CONTROL_FRAME(32), .NB_ID(6),
                           .CONTROLLER_ID(6'd4)) dut3 (
    .i_clock(clk), .i_reset(rst), .i_request_select(sel), .i_request_valid(vld),
    .i_data_from_mips(data_s[3][19:0]), .bus(if3.master));

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: a snapshot becomes a queue of padded frames; each accepted frame pops one.
  task automatic model_edge();
    logic [31:0] f;
    int nfr;
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        exp_q[k].delete();
        done_pend[k] = 1'b0;
      end else if (done_pend[k]) begin
        done_pend[k] = 1'b0;
      end else if (exp_q[k].size() > 0) begin
        if (ready_s[k]) begin
          void'(exp_q[k].pop_front());
          if (exp_q[k].size() == 0) done_pend[k] = 1'b1;
        end
      end else if (vld && (sel == 6'(k + 1))) begin
        nfr = (nbits[k] + 31) / 32;
        for (int j = 0; j < nfr; j++) begin
          f = 32'h0;
          for (int b = 0; b < 32; b++) begin
            if (32 * j + b < nbits[k]) f[b] = data_s[k][32 * j + b];
          end
          exp_q[k].push_back(f);
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [31:0] ef;
    for (int k = 0; k < 4; k++) begin
      ef = (exp_q[k].size() > 0) ? exp_q[k][0] : 32'h0;
      check_eq($sformatf("u%0d_frame", k), 64'(frame_s[k]), 64'(ef));
      check_eq($sformatf("u%0d_writing", k), 64'(wr_s[k]), 64'(exp_q[k].size() > 0));
      check_eq($sformatf("u%0d_last", k), 64'(last_s[k]), 64'(exp_q[k].size() == 1));
      check_eq($sformatf("u%0d_busy", k), 64'(busy_s[k]),
               64'((exp_q[k].size() > 0) || done_pend[k]));
      check_eq($sformatf("u%0d_done", k), 64'(done_s[k]), 64'(done_pend[k]));
      if (done_s[k]) dones[k]++;
    end
  endtask

  task automatic step();
    for (int k = 0; k < 4; k++) begin
      if (!rst && wr_s[k] && ready_s[k]) xfers[k]++;
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic reset_mid();
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("rst_u%0d_writing", k), 64'(wr_s[k]), 64'h0);
      check_eq($sformatf("rst_u%0d_busy", k), 64'(busy_s[k]), 64'h0);
      check_eq($sformatf("rst_u%0d_last", k), 64'(last_s[k]), 64'h0);
      check_eq($sformatf("rst_u%0d_frame", k), 64'(frame_s[k]), 64'h0);
      exp_q[k].delete();
      done_pend[k] = 1'b0;
    end
    step();
    rst = 1'b0;
  endtask

  task automatic request(input logic [5:0] id);
    sel = id;
    vld = 1'b1;
    step();
    vld = 1'b0;
  endtask

  int x0, d0;

  initial begin
    rst = 1'b1; vld = 1'b0; sel = 6'd0;
    for (int k = 0; k < 4; k++) begin
      data_s[k] = 144'h0; ready_s[k] = 1'b1; xfers[k] = 0; dones[k] = 0; done_pend[k] = 1'b0;
    end
    @(negedge clk); @(negedge clk);
    check_outputs();
    rst = 1'b0;
    step();

    // 96-bit snapshot, always ready
    data_s[0] = 144'({24{4'hA}});
    x0 = xfers[0]; d0 = dones[0];
    request(6'd1);
    repeat (5) step();
    check_eq("s1_frames", 64'(xfers[0] - x0), 64'd3);
    check_eq("s1_dones", 64'(dones[0] - d0), 64'd1);

    // 104-bit snapshot, padded last frame
    data_s[1] = 144'({26{4'hB}});
    x0 = xfers[1];
    request(6'd2);
    repeat (6) step();
    check_eq("s2_frames", 64'(xfers[1] - x0), 64'd4);

    // 144-bit snapshot with a 5-cycle stall on frame 1
    data_s[2] = 144'({36{4'hC}});
    x0 = xfers[2];
    request(6'd3);
    step();
    ready_s[2] = 1'b0;
    repeat (5) step();
    ready_s[2] = 1'b1;
    repeat (6) step();
    check_eq("s3_frames", 64'(xfers[2] - x0), 64'd5);

    // matching request held during SEND is ignored
    data_s[0] = 144'h0000_1111_2222_3333_4444_5555;
    x0 = xfers[0]; d0 = dones[0];
    sel = 6'd1; vld = 1'b1;
    repeat (3) step();
    vld = 1'b0;
    repeat (4) step();
    check_eq("s4_frames", 64'(xfers[0] - x0), 64'd3);
    check_eq("s4_dones", 64'(dones[0] - d0), 64'd1);

    // data changes right after capture
    data_s[0] = 144'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    request(6'd1);
    data_s[0] = 144'h0;
    repeat (5) step();

    // reset while frame 1 of 3 is on the link
    data_s[0] = 144'({24{4'h5}});
    ready_s[0] = 1'b0;
    request(6'd1);
    ready_s[0] = 1'b1;
    step();
    ready_s[0] = 1'b0;
    step();
    reset_mid();
    ready_s[0] = 1'b1;
    repeat (4) step();
    x0 = xfers[0];
    request(6'd1);
    repeat (5) step();
    check_eq("s6_frames", 64'(xfers[0] - x0), 64'd3);

    // single-frame instance
    data_s[3] = 144'h0000_0000_0000_0000_0000_0000_00F_ABCD;
    x0 = xfers[3];
    request(6'd4);
    repeat (3) step();
    check_eq("s7_frames", 64'(xfers[3] - x0), 64'd1);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      vld = ($urandom_range(0, 3) == 0);
      sel = 6'($urandom_range(0, 6));
      for (int k = 0; k < 4; k++) begin
        ready_s[k] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 1) == 1)
          data_s[k] = 144'({$urandom, $urandom, $urandom, $urandom, $urandom});
      end
      if ($urandom_range(0, 299) == 0) reset_mid();
      else step();
    end
    vld = 1'b0;
    for (int k = 0; k < 4; k++) ready_s[k] = 1'b1;
    repeat (8) step();
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("end_u%0d_busy", k), 64'(busy_s[k]), 64'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/debug_frame_serializer.md
Name: debug_frame_serializer

Overview:
Parametrised successor to the per-stage debug controller. Snapshots a wide MIPS debug vector when its controller ID is requested. Streams the snapshot as fixed-width frames to the debug interface (UART/host link) with a valid/ready handshake, last-frame marking and zero padding. One instance per pipeline-stage latch group; all instances share the request bus, and their outputs feed the interface arbiter.

Parameters:
NB_INPUT_SIZE, 96, width of debug vector from MIPS (any value >= 1)
NB_CONTROL_FRAME, 32, width of one output frame
NB_ID, 6, width of request select / controller ID
CONTROLLER_ID, 6'b000001, ID this instance answers to
N_FRAMES (localparam), ceil(NB_INPUT_SIZE/NB_CONTROL_FRAME), frames per snapshot
NB_CNT (localparam), max(1, clog2(N_FRAMES)), frame counter width

Ports:
i_clock  in  1  system clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_request_select  in  NB_ID  ID of the controller being requested
i_request_valid  in  1  request strobe; qualifies i_request_select
i_data_from_mips  in  NB_INPUT_SIZE  live debug vector
i_ready  in  1  interface accepts current frame this cycle
o_frame_to_interface  out  NB_CONTROL_FRAME  current frame payload
o_writing  out  1  frame valid
o_last  out  1  current frame is final frame of snapshot
o_busy  out  1  serializer not in IDLE
o_done  out  1  one-cycle pulse after final frame accepted

Behaviour:
- Reset (async assert, sync-safe deassert): state IDLE. All outputs 0: frame, o_writing, o_last, o_busy, o_done. Snapshot register and frame counter cleared.
- States: IDLE, SEND, DONE.
- IDLE: if i_request_valid && i_request_select==CONTROLLER_ID at edge t:
  - snapshot <= i_data_from_mips, zero-extended to N_FRAMES*NB_CONTROL_FRAME
  - counter <= 0; state -> SEND
  - o_writing=1 with frame 0 from cycle t+1 (one-cycle latency)
  - A mismatched ID or i_request_valid=0 causes no action.
- SEND:
  - o_frame_to_interface = snapshot[counter*NB_CONTROL_FRAME +: NB_CONTROL_FRAME]; least-significant frame first.
  - o_writing=1 for the whole state.
  - o_last = (counter==N_FRAMES-1).
  - Transfer occurs on an edge where o_writing && i_ready.
  - Transfer of a non-last frame: counter+1.
  - Transfer of the last frame: state -> DONE.
  - i_ready=0 holds frame, counter and o_last stable. No limit on stall length.
- DONE: one cycle. o_done=1, o_writing=0, o_last=0, o_busy=1. Then IDLE.
- o_busy=1 in SEND and DONE.
- Requests arriving in SEND or DONE are ignored, not queued. A new request is accepted only in IDLE, earliest the cycle after o_done.
- Changes to i_data_from_mips after the capture edge do not affect frames in flight.
- Padding: bits above NB_INPUT_SIZE in the final frame are 0.
- NB_INPUT_SIZE <= NB_CONTROL_FRAME: N_FRAMES=1. Single frame with o_last=1 from the first SEND cycle.
- Reset mid-SEND: outputs drop to 0 immediately (async). The snapshot is discarded. After release, no frames are emitted until a new matching request.
- Counter never exceeds N_FRAMES-1. No wrap-around is possible.

Test Plan:
- NB_INPUT_SIZE=96, data {24{4'hA}}, request ID 6'b000001 with i_ready=1 -> 3 frames 0xAAAAAAAA on consecutive cycles starting 1 cycle after request; o_last only on 3rd; o_done pulse next cycle; o_busy 0 afterwards.
- NB_INPUT_SIZE=104, data {26{4'hB}}, ID 6'b000010 -> 4 frames: 0xBBBBBBBB x3, then 0x000000BB with o_last=1.
- Backpressure: 144-bit {36{4'hC}}, i_ready low 5 cycles on frame 1 -> frame 1 held stable while o_writing=1; total 5 frames, no duplication or loss.
- Request ID 6'b000011 to an instance with ID 6'b000001 -> o_writing and o_busy stay 0. Matching request issued during SEND -> ignored; exactly N_FRAMES frames, one o_done.
- Data change after capture: change data to all-0 one cycle after request -> frames still carry captured value.
- Reset asserted mid-frame 1 of 3 -> all outputs 0 same cycle; after release idle until new request, which yields full 3 frames from frame 0.
